// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serialiser, LSB first, idle-high registered line.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_d;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     shift, shift_d;
    logic [2:0]     bit_idx, bit_d;
    logic [BW-1:0]  baud, baud_d;
    logic           txd_d, push, pop, tick, full, empty;

    assign full     = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign empty    = fifo_count == '0;
    assign tx_ready = !full;
    assign busy     = (state != IDLE) || !empty;
    assign tick     = baud == BW'(CPB - 1);
    assign push     = tx_valid && !full;

    always_comb begin
        state_d = state;
        shift_d = shift;
        bit_d   = bit_idx;
        baud_d  = tick ? '0 : baud + 1'b1;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (tick) begin
                if (bit_idx == 3'd7) state_d = STOP;
                else begin
                    bit_d   = bit_idx + 3'd1;
                    shift_d = shift >> 1;
                end
            end
            STOP: if (tick) begin
                // chain straight into the next start bit so frames stay contiguous
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            baud       <= '0;
            uart_txd   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            bit_idx    <= bit_d;
            baud       <= baud_d;
            uart_txd   <= txd_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            overflow   <= overflow | (tx_valid && full);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_txd, busy, overflow;
    logic [4:0] fifo_count;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         peak = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    logic [7:0] vec [32];

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_txd(uart_txd), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // line monitor: one sample per cycle, bits taken mid-bit (10 clocks per bit)
    initial begin
        logic       act;
        logic       prev;
        int         cnt;
        logic [7:0] byte_q;
        act = 1'b0;
        prev = 1'b1;
        cnt = 0;
        byte_q = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                act = 1'b0;
                prev = 1'b1;
            end else begin
                if (!act) begin
                    if (prev && !uart_txd) begin
                        act = 1'b1;
                        cnt = 0;
                        starts.push_back(cyc);
                    end
                end else begin
                    cnt++;
                    if (cnt == 5) check("start_bit", uart_txd, 0);
                    else if (cnt >= 15 && cnt <= 85 && cnt % 10 == 5) byte_q[(cnt-15)/10] = uart_txd;
                    else if (cnt == 95) begin
                        check("stop_bit", uart_txd, 1);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_frame: got %0h expected none", byte_q);
                        end else check("frame_byte", byte_q, exp_q.pop_front());
                        act = 1'b0;
                    end
                end
                prev = uart_txd;
            end
        end
    end

    task automatic burst(input int n, input int nacc);
        for (int i = 0; i < n; i++) begin
            tx_data = vec[i];
            tx_valid = 1'b1;
            if (i < nacc) exp_q.push_back(vec[i]);
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = fifo_count;
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        int k;
        int lows;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset / idle state
        repeat (50) @(negedge clk);
        check("t1_txd", uart_txd, 1);
        check("t1_ready", tx_ready, 1);
        check("t1_busy", busy, 0);
        check("t1_count", fifo_count, 0);
        check("t1_overflow", overflow, 0);

        // 2: single 0xA5 frame, busy length
        starts.delete();
        vec[0] = 8'hA5;
        burst(1, 1);
        wait_idle(300);
        check("t2_frames", starts.size(), 1);
        if (starts.size() > 0) check("t2_busy_len", cyc - starts[0], 100);

        // 3: three back-to-back bytes, contiguous frames
        starts.delete();
        peak = 0;
        vec[0] = 8'h55; vec[1] = 8'h0F; vec[2] = 8'hFF;
        burst(3, 3);
        wait_idle(500);
        check("t3_peak", peak, 2);
        check("t3_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("t3_gap1", starts[1] - starts[0], 100);
            check("t3_gap2", starts[2] - starts[1], 100);
        end

        // 4: 17 accepted, 18th dropped with overflow
        for (int i = 0; i < 18; i++) vec[i] = 8'(8'h11 * i + 8'h03);
        burst(18, 17);
        check("t4_count_full", fifo_count, 16);
        check("t4_ready", tx_ready, 0);
        check("t4_overflow", overflow, 1);
        wait_idle(2500);
        check("t4_overflow_sticky", overflow, 1);
        check("t4_count_end", fifo_count, 0);

        // 5: reset in DATA bit 3 of 0x00
        vec[0] = 8'h00; vec[1] = 8'h33;
        burst(2, 0);
        k = 0;
        while (uart_txd && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_frame_started", uart_txd, 0);
        repeat (44) @(negedge clk);
        check("t5_bit3_low", uart_txd, 0);
        #2 reset = 1'b1;
        #1;
        check("t5_txd_async", uart_txd, 1);
        check("t5_count", fifo_count, 0);
        check("t5_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        starts.delete();
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!uart_txd) lows++;
        end
        check("t5_line_quiet", lows, 0);
        check("t5_no_frames", starts.size(), 0);

        // 6: push while full on the STOP->START pop cycle
        starts.delete();
        for (int i = 0; i < 17; i++) vec[i] = 8'(8'hF0 - 8'h07 * i);
        burst(17, 17);
        check("t6_frames_seen", starts.size(), 1);
        if (starts.size() > 0) begin
            k = 0;
            while (cyc < starts[0] + 99 && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("t6_align", cyc, starts[0] + 99);
            check("t6_count_pre", fifo_count, 16);
            check("t6_overflow_pre", overflow, 0);
            tx_data = 8'hEE;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            check("t6_count_post", fifo_count, 15);
            check("t6_overflow_post", overflow, 1);
            check("t6_ready_post", tx_ready, 1);
        end
        wait_idle(2500);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
